tile_addr_gen: RTL and testbench



---
 rtl/tile_addr_gen.sv | 168 ++++++++++++++++
 tb/tb_tile_addr_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_addr_gen.sv
// Operand-A tile address generator: walks a row-major m x n operand band by band,
// emitting one bus-beat read address per cycle into an address FIFO.
module tile_addr_gen #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DIM_WIDTH     = 16,
    parameter int ARRAY_HEIGHT  = 4,
    parameter int BUS_WIDTH     = 256,
    parameter int ELEMENT_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DIM_WIDTH-1:0]  m_i,
    input  logic [DIM_WIDTH-1:0]  n_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [DIM_WIDTH-1:0]  repeat_i,
    output logic [ADDR_WIDTH-1:0] fifo_addr_o,
    output logic                  fifo_last_o,
    output logic                  fifo_incr_o,
    input  logic                  fifo_full_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            dbg_state
);

    localparam int HB  = $clog2(ARRAY_HEIGHT);
    localparam int DW1 = DIM_WIDTH + 1;
    localparam int DW2 = DIM_WIDTH + 2;
    localparam logic [DW1-1:0]        BEAT_ELEMS = DW1'(BUS_WIDTH / (8 * ELEMENT_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BUS_WIDTH / 8);
    localparam logic [DW1-1:0]        H_STEP     = DW1'(ARRAY_HEIGHT);
    localparam logic [HB-1:0]         ROW_MAX    = HB'(ARRAY_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EMIT      = 3'd1,
        S_NEXT_COL  = 3'd2,
        S_NEXT_BAND = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DIM_WIDTH-1:0]  m_q, n_q, repeat_q, rep;
    logic [ADDR_WIDTH-1:0] stride_q, band_base, row_ptr, col_off, band_step;
    logic [DW1-1:0]        r0, col, col_next, r0_next;
    logic [HB-1:0]         row_idx;
    logic [DW2-1:0]        rows_done;
    logic                  row_last, col_more, rep_more, band_more, final_group;
    logic                  accept, empty_job, push_d, done_d, busy_nx;

    assign dbg_state   = state;
    assign band_step   = stride_q << HB;
    assign rows_done   = DW2'(r0) + DW2'(row_idx) + DW2'(1);
    assign row_last    = (row_idx == ROW_MAX) || (rows_done >= DW2'(m_q));
    assign col_next    = col + BEAT_ELEMS;
    assign col_more    = col_next < DW1'(n_q);
    assign rep_more    = (DW1'(rep) + DW1'(1)) < DW1'(repeat_q);
    assign r0_next     = r0 + H_STEP;
    assign band_more   = r0_next < DW1'(m_q);
    // The final group finishes straight from EMIT so done follows the last push by one cycle.
    assign final_group = !col_more && !rep_more && !band_more;
    assign empty_job   = (m_i == '0) || (n_i == '0) || (repeat_i == '0);
    assign accept      = (state == S_IDLE) && start_i && !abort_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort_i && state != S_IDLE) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (start_i) state_nx = empty_job ? S_FINISH : S_EMIT;
                S_EMIT:      if (!fifo_full_i && row_last) state_nx = final_group ? S_FINISH : S_NEXT_COL;
                S_NEXT_COL:  state_nx = col_more ? S_EMIT : S_NEXT_BAND;
                S_NEXT_BAND: state_nx = (rep_more || band_more) ? S_EMIT : S_FINISH;
                S_FINISH:    state_nx = S_IDLE;
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    // Push handshake: an address is decided in EMIT when fifo_full_i is low and
    // appears on fifo_addr_o/fifo_last_o with fifo_incr_o one cycle later; the
    // FIFO raises full while one entry is still free to absorb that in-flight push.
    always_comb begin
        push_d  = (state == S_EMIT) && !fifo_full_i && !abort_i;
        done_d  = (state == S_FINISH) && !abort_i;
        busy_nx = busy_o;
        if (accept) busy_nx = 1'b1;
        if (state != S_IDLE && (abort_i || state == S_FINISH)) busy_nx = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_addr_o <= '0;
            fifo_last_o <= 1'b0;
            fifo_incr_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            m_q         <= '0;
            n_q         <= '0;
            repeat_q    <= '0;
            stride_q    <= '0;
            rep         <= '0;
            r0          <= '0;
            col         <= '0;
            row_idx     <= '0;
            band_base   <= '0;
            row_ptr     <= '0;
            col_off     <= '0;
        end else begin
            fifo_incr_o <= push_d;
            fifo_last_o <= push_d && row_last;
            done_o      <= done_d;
            busy_o      <= busy_nx;
            if (push_d) fifo_addr_o <= row_ptr;
            if (accept) begin
                m_q       <= m_i;
                n_q       <= n_i;
                repeat_q  <= repeat_i;
                stride_q  <= stride_i;
                rep       <= '0;
                r0        <= '0;
                col       <= '0;
                row_idx   <= '0;
                band_base <= base_addr_i;
                row_ptr   <= base_addr_i;
                col_off   <= '0;
            end else if (!abort_i) begin
                case (state)
                    S_EMIT: begin
                        if (!fifo_full_i) begin
                            row_ptr <= row_ptr + stride_q;
                            row_idx <= row_last ? '0 : row_idx + HB'(1);
                        end
                    end
                    S_NEXT_COL: begin
                        col     <= col_next;
                        col_off <= col_off + BEAT_BYTES;
                        row_ptr <= band_base + col_off + BEAT_BYTES;
                    end
                    S_NEXT_BAND: begin
                        col     <= '0;
                        col_off <= '0;
                        if (rep_more) begin
                            rep     <= rep + DIM_WIDTH'(1);
                            row_ptr <= band_base;
                        end else begin
                            rep       <= '0;
                            r0        <= r0_next;
                            band_base <= band_base + band_step;
                            row_ptr   <= band_base + band_step;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: directed jobs, a loop-nest reference model of the
// traversal order, and literal address tables for the simple cases.
module tb_tile_addr_gen;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int H  = 4;
    localparam int BEAT_ELEMS = 32;
    localparam int BEAT_BYTES = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i, abort_i, fifo_full_i;
    logic [DW-1:0] m_i, n_i, repeat_i;
    logic [AW-1:0] stride_i, base_addr_i;
    logic [AW-1:0] fifo_addr_o;
    logic          fifo_last_o, fifo_incr_o, busy_o, done_o;
    logic [2:0]    dbg_state;

    logic [AW:0] exp_q[$];
    logic [AW:0] got_q[$];
    logic [AW:0] tbl[$];
    logic [AW:0] exp_e;
    logic        full_at_edge = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    tile_addr_gen #(
        .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .ARRAY_HEIGHT(H), .BUS_WIDTH(256), .ELEMENT_WIDTH(1)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .m_i(m_i), .n_i(n_i), .stride_i(stride_i), .base_addr_i(base_addr_i),
        .repeat_i(repeat_i), .fifo_addr_o(fifo_addr_o), .fifo_last_o(fifo_last_o),
        .fifo_incr_o(fifo_incr_o), .fifo_full_i(fifo_full_i), .busy_o(busy_o),
        .done_o(done_o), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) full_at_edge <= fifo_full_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // reference model: the traversal loop nest with plain arithmetic
    task automatic build_exp(input int m, input int n, input int stride, input int base, input int rep);
        longint a;
        int rows;
        for (int r0 = 0; r0 < m; r0 += H)
            for (int rp = 0; rp < rep; rp++)
                for (int c = 0; c < n; c += BEAT_ELEMS) begin
                    rows = (m - r0 < H) ? (m - r0) : H;
                    for (int i = 0; i < rows; i++) begin
                        a = longint'(base) + longint'(r0 + i) * longint'(stride)
                            + longint'(c / BEAT_ELEMS) * BEAT_BYTES;
                        exp_q.push_back({(i == rows - 1), AW'(a % 65536)});
                    end
                end
    endtask

    // scoreboard: every push is checked against the model queue
    always @(negedge clk) begin
        if (!reset && fifo_incr_o) begin
            got_q.push_back({fifo_last_o, fifo_addr_o});
            chk("push_while_full", full_at_edge, 0);
            chk("push_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk("push_addr", fifo_addr_o, exp_e[AW-1:0]);
                chk("push_last", fifo_last_o, exp_e[AW]);
            end
        end
    end

    task automatic check_got(input string tag);
        chk({tag, "_tbl_len"}, got_q.size(), tbl.size());
        for (int i = 0; i < tbl.size() && i < got_q.size(); i++)
            chk({tag, "_tbl_entry"}, got_q[i], tbl[i]);
    endtask

    task automatic drive_start(input int m, input int n, input int stride, input int base, input int rep);
        @(negedge clk);
        m_i = DW'(m); n_i = DW'(n); stride_i = AW'(stride); base_addr_i = AW'(base);
        repeat_i = DW'(rep); start_i = 1'b1;
    endtask

    task automatic run_job(input string tag, input int m, input int n, input int stride, input int base,
                           input int rep, input int full_at, input int full_len, input bit poke_start);
        int cyc, pushes, last_push, done_cyc, full_left, expected_n;
        bit full_done, busy_c1;
        exp_q.delete();
        got_q.delete();
        build_exp(m, n, stride, base, rep);
        expected_n = exp_q.size();
        drive_start(m, n, stride, base, rep);
        cyc = 0; pushes = 0; last_push = -1; done_cyc = -1; full_left = 0; full_done = 0; busy_c1 = 0;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (cyc == 1) busy_c1 = busy_o;
            if (fifo_incr_o) begin pushes++; last_push = cyc; end
            if (done_o) done_cyc = cyc;
            if (poke_start && cyc == 3) begin
                m_i = 1; n_i = 1; repeat_i = 1; base_addr_i = 16'h4444; start_i = 1'b1;
            end
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) fifo_full_i = 1'b0;
            end else if (!full_done && full_at > 0 && pushes == full_at) begin
                fifo_full_i = 1'b1;
                full_left = full_len;
                full_done = 1'b1;
            end
        end
        fifo_full_i = 1'b0;
        chk({tag, "_busy_after_start"}, busy_c1, 1);
        chk({tag, "_done_seen"}, done_cyc > 0, 1);
        chk({tag, "_push_count"}, pushes, expected_n);
        chk({tag, "_model_drained"}, exp_q.size(), 0);
        if (expected_n == 0) chk({tag, "_empty_done_cycle"}, done_cyc, 2);
        else                 chk({tag, "_done_after_last"}, done_cyc, last_push + 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_o, 0);
        chk({tag, "_busy_end"}, busy_o, 0);
    endtask

    task automatic wait_pushes(input int target, output int seen);
        int cyc;
        seen = 0;
        cyc = 0;
        while (seen < target && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (fifo_incr_o) seen++;
        end
        chk("wait_pushes", seen, target);
    endtask

    initial begin
        int seen, extra, dones;
        reset = 1'b1; start_i = 0; abort_i = 0; fifo_full_i = 0;
        m_i = 0; n_i = 0; repeat_i = 0; stride_i = 0; base_addr_i = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {fifo_addr_o, fifo_last_o, fifo_incr_o, busy_o, done_o, dbg_state}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {fifo_addr_o, fifo_last_o, fifo_incr_o, busy_o, done_o, dbg_state}, 0);

        run_job("single_band", 4, 32, 32, 16'h0100, 1, 0, 0, 0);
        tbl = '{17'h00100, 17'h00120, 17'h00140, 17'h10160};
        check_got("single_band");

        run_job("partial_band", 6, 64, 64, 0, 1, 0, 0, 0);
        tbl = '{17'h00000, 17'h00040, 17'h00080, 17'h100C0, 17'h00020, 17'h00060,
                17'h000A0, 17'h100E0, 17'h00100, 17'h10140, 17'h00120, 17'h10160};
        check_got("partial_band");

        run_job("repeat2", 4, 32, 32, 0, 2, 0, 0, 1);
        tbl = '{17'h00000, 17'h00020, 17'h00040, 17'h10060,
                17'h00000, 17'h00020, 17'h00040, 17'h10060};
        check_got("repeat2");

        run_job("full_stall", 6, 64, 64, 0, 1, 3, 5, 0);
        tbl = '{17'h00000, 17'h00040, 17'h00080, 17'h100C0, 17'h00020, 17'h00060,
                17'h000A0, 17'h100E0, 17'h00100, 17'h10140, 17'h00120, 17'h10160};
        check_got("full_stall");

        run_job("empty_m", 0, 32, 32, 0, 1, 0, 0, 0);
        run_job("empty_rep", 4, 32, 32, 0, 0, 0, 0, 0);

        run_job("wrap", 4, 32, 16'h10, 16'hFFF0, 1, 0, 0, 0);
        tbl = '{17'h0FFF0, 17'h00000, 17'h00010, 17'h10020};
        check_got("wrap");

        run_job("wide", 7, 96, 100, 16'h1234, 2, 0, 0, 0);

        // abort after the 2nd push
        exp_q.delete();
        build_exp(6, 64, 64, 0, 1);
        drive_start(6, 64, 64, 0, 1);
        wait_pushes(2, seen);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy_low", busy_o, 0);
        extra = fifo_incr_o ? 1 : 0;
        dones = done_o ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_incr_o) extra++;
            if (done_o) dones++;
        end
        chk("abort_extra_pushes_le1", extra <= 1, 1);
        chk("abort_no_done", dones, 0);
        chk("abort_state_idle", dbg_state, 0);
        exp_q.delete();

        run_job("after_abort", 4, 32, 32, 16'h0100, 1, 0, 0, 0);

        // reset in the middle of a job
        exp_q.delete();
        build_exp(6, 64, 64, 0, 1);
        drive_start(6, 64, 64, 0, 1);
        wait_pushes(2, seen);
        reset = 1'b1;
        #1;
        chk("midjob_reset_outputs", {fifo_addr_o, fifo_last_o, fifo_incr_o, busy_o, done_o, dbg_state}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_idle", {fifo_incr_o, busy_o, done_o, dbg_state}, 0);

        run_job("after_reset", 4, 32, 16'h10, 16'hFFF0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
